// File: rtl/ext_fifo_ipa.sv
// ext_fifo_ipa: parametrised single-clock valid/ready FIFO with
// optional fall-through, flush, occupancy count and almost-full flag.
module ext_fifo_ipa #(
   parameter int DATA_WIDTH     = 32,
   parameter int BUFFER_DEPTH   = 4,
   parameter int ALMOST_FULL_TH = BUFFER_DEPTH - 1,
   parameter bit FALL_THROUGH   = 1'b0,
   parameter int CNT_W          = $clog2(BUFFER_DEPTH + 1)
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   input  logic                  flush_i,
   input  logic                  valid_i,
   input  logic [DATA_WIDTH-1:0] data_i,
   output logic                  ready_o,
   output logic                  valid_o,
   output logic [DATA_WIDTH-1:0] data_o,
   input  logic                  ready_i,
   output logic [CNT_W-1:0]      count_o,
   output logic                  almost_full_o,
   output logic                  empty_o
);

   localparam int PTR_W = (BUFFER_DEPTH > 1) ? $clog2(BUFFER_DEPTH) : 1;

   logic [DATA_WIDTH-1:0] r_mem [BUFFER_DEPTH];
   logic [PTR_W-1:0]      r_wr;
   logic [PTR_W-1:0]      r_rd;
   logic [CNT_W-1:0]      r_cnt;

   logic w_full;
   logic w_empty;
   logic w_bypass;
   logic w_push;
   logic w_wr;
   logic w_rd;

   // Wrap at BUFFER_DEPTH-1 so non-power-of-two depths work.
   function automatic logic [PTR_W-1:0] f_inc(input logic [PTR_W-1:0] p);
      if (p == PTR_W'(BUFFER_DEPTH - 1)) return '0;
      return p + PTR_W'(1);
   endfunction

   assign w_empty = (r_cnt == '0);
   assign w_full  = (r_cnt == CNT_W'(BUFFER_DEPTH));

   assign ready_o = !w_full && !flush_i;
   assign w_push  = valid_i && ready_o;

   always_comb begin
      valid_o = 1'b0;
      data_o  = r_mem[r_rd];
      if (!w_empty) begin
         valid_o = !flush_i;
      end else if (FALL_THROUGH) begin
         valid_o = valid_i && !flush_i;
         data_o  = data_i;
      end
   end

   // A bypassed beat leaves storage, pointers and count untouched.
   assign w_bypass = FALL_THROUGH && w_empty && w_push && ready_i;
   assign w_wr     = w_push && !w_bypass;
   assign w_rd     = !w_empty && valid_o && ready_i;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < BUFFER_DEPTH; i++) r_mem[i] <= '0;
      end else if (w_wr && !flush_i) begin
         r_mem[r_wr] <= data_i;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else if (flush_i) begin
         r_wr  <= '0;
         r_rd  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_wr) r_wr <= f_inc(r_wr);
         if (w_rd) r_rd <= f_inc(r_rd);
         if (w_wr && !w_rd) r_cnt <= r_cnt + CNT_W'(1);
         else if (w_rd && !w_wr) r_cnt <= r_cnt - CNT_W'(1);
      end
   end

   assign count_o       = r_cnt;
   assign empty_o       = w_empty;
   assign almost_full_o = (r_cnt >= CNT_W'(ALMOST_FULL_TH));

endmodule

// File: tb/tb_ext_fifo_ipa.sv
// Directed bench for ext_fifo_ipa: registered depth 4 and 3,
// fall-through depth 4; fill, drain, wrap, flush and async reset.
module tb_ext_fifo_ipa;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   int total = 0;
   int passed = 0;
   int fails = 0;

   // DUT A: depth 4, TH 3, registered
   logic a_flush = 0, a_vi = 0, a_ri = 0;
   logic [7:0] a_di = 0, a_do;
   logic a_ro, a_vo, a_af, a_em;
   logic [2:0] a_cnt;

   // DUT B: depth 3, registered
   logic b_flush = 0, b_vi = 0, b_ri = 0;
   logic [7:0] b_di = 0, b_do;
   logic b_ro, b_vo, b_af, b_em;
   logic [1:0] b_cnt;

   // DUT C: depth 4, fall-through
   logic c_flush = 0, c_vi = 0, c_ri = 0;
   logic [7:0] c_di = 0, c_do;
   logic c_ro, c_vo, c_af, c_em;
   logic [2:0] c_cnt;

   ext_fifo_ipa #(.DATA_WIDTH(8), .BUFFER_DEPTH(4),
      .ALMOST_FULL_TH(3), .FALL_THROUGH(1'b0)) u_a (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(a_flush),
      .valid_i(a_vi), .data_i(a_di), .ready_o(a_ro),
      .valid_o(a_vo), .data_o(a_do), .ready_i(a_ri),
      .count_o(a_cnt), .almost_full_o(a_af), .empty_o(a_em));

   ext_fifo_ipa #(.DATA_WIDTH(8), .BUFFER_DEPTH(3),
      .ALMOST_FULL_TH(2), .FALL_THROUGH(1'b0)) u_b (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(b_flush),
      .valid_i(b_vi), .data_i(b_di), .ready_o(b_ro),
      .valid_o(b_vo), .data_o(b_do), .ready_i(b_ri),
      .count_o(b_cnt), .almost_full_o(b_af), .empty_o(b_em));

   ext_fifo_ipa #(.DATA_WIDTH(8), .BUFFER_DEPTH(4),
      .ALMOST_FULL_TH(3), .FALL_THROUGH(1'b1)) u_c (
      .clk_i(clk), .rst_ni(rst_n), .flush_i(c_flush),
      .valid_i(c_vi), .data_i(c_di), .ready_o(c_ro),
      .valid_o(c_vo), .data_o(c_do), .ready_i(c_ri),
      .count_o(c_cnt), .almost_full_o(c_af), .empty_o(c_em));

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Inputs change 2 time units after the rising edge.
   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   initial begin
      int sent, rcvd, maxc, cyc;
      // reset state
      #3;
      chk("rst_cnt", a_cnt, 0);
      chk("rst_empty", a_em, 1);
      chk("rst_af", a_af, 0);
      chk("rst_ready", a_ro, 1);
      chk("rst_valid", a_vo, 0);
      chk("rst_data", a_do, 0);
      chk("rst_c_valid", c_vo, 0);
      #4 rst_n = 1'b1;
      tick();

      // fill A with A0..A3, consumer stalled
      a_ri = 0;
      a_vi = 1; a_di = 8'hA0; tick();
      #1 chk("fill_cnt1", a_cnt, 1);
      chk("fill_af1", a_af, 0);
      a_di = 8'hA1; tick();
      #1 chk("fill_cnt2", a_cnt, 2);
      chk("fill_af2", a_af, 0);
      a_di = 8'hA2; tick();
      #1 chk("fill_cnt3", a_cnt, 3);
      chk("fill_af3", a_af, 1);
      chk("fill_rdy3", a_ro, 1);
      a_di = 8'hA3; tick();
      #1 chk("fill_cnt4", a_cnt, 4);
      chk("fill_rdy4", a_ro, 0);
      a_di = 8'hA4; tick();
      #1 chk("full_cnt", a_cnt, 4);
      chk("full_head", a_do, 8'hA0);

      // drain in order
      a_vi = 0; a_ri = 1;
      for (int i = 0; i < 4; i++) begin
         #1 chk("drain_valid", a_vo, 1);
         chk("drain_data", a_do, 8'hA0 + i);
         tick();
      end
      #1 chk("drain_vo", a_vo, 0);
      chk("drain_empty", a_em, 1);

      // simultaneous push and pop at count 2
      a_ri = 0; a_vi = 1;
      a_di = 8'hB0; tick();
      a_di = 8'hB1; tick();
      #1 chk("pp_cnt_pre", a_cnt, 2);
      a_di = 8'hB2; a_ri = 1;
      #1 chk("pp_head", a_do, 8'hB0);
      tick();
      #1 chk("pp_cnt", a_cnt, 2);
      chk("pp_next", a_do, 8'hB1);

      // flush at count 3 with push and pop active
      a_ri = 0; a_di = 8'hB3; tick();
      #1 chk("fl_cnt_pre", a_cnt, 3);
      a_vi = 1; a_di = 8'hB4; a_ri = 1; a_flush = 1;
      #1 chk("fl_valid", a_vo, 0);
      chk("fl_ready", a_ro, 0);
      tick();
      a_flush = 0; a_vi = 0; a_ri = 0;
      #1 chk("fl_cnt", a_cnt, 0);
      chk("fl_empty", a_em, 1);
      chk("fl_ready_after", a_ro, 1);
      a_vi = 1; a_di = 8'hC0; tick();
      a_vi = 0;
      #1 chk("fl_new_valid", a_vo, 1);
      chk("fl_new_data", a_do, 8'hC0);
      chk("fl_new_cnt", a_cnt, 1);

      // depth 3 streaming with consumer toggling 1,0,1,0
      sent = 0; rcvd = 0; maxc = 0; cyc = 0;
      while (rcvd < 20 && cyc < 200) begin
         b_vi = (sent < 20);
         b_di = 8'(sent);
         b_ri = (cyc % 2 == 0);
         #1;
         if (b_vo && b_ri) begin
            chk("wrap_data", b_do, rcvd);
            rcvd++;
         end
         if (b_vi && b_ro) sent++;
         tick();
         if (int'(b_cnt) > maxc) maxc = int'(b_cnt);
         cyc++;
      end
      b_vi = 0; b_ri = 0;
      chk("wrap_rcvd", rcvd, 20);
      chk("wrap_max3", maxc <= 3, 1);
      chk("wrap_hit3", maxc, 3);
      #1 chk("wrap_empty", b_em, 1);

      // fall-through bypass
      c_vi = 1; c_di = 8'h55; c_ri = 1;
      #1 chk("ft_valid", c_vo, 1);
      chk("ft_data", c_do, 8'h55);
      tick();
      #1 chk("ft_cnt", c_cnt, 0);
      c_ri = 0;
      #1 chk("ft_stall_valid", c_vo, 1);
      tick();
      c_vi = 0; c_di = 8'h00;
      #1 chk("ft_stall_cnt", c_cnt, 1);
      chk("ft_stall_data", c_do, 8'h55);
      chk("ft_stall_vo", c_vo, 1);

      // async reset between edges
      #2 rst_n = 1'b0;
      #1 chk("arst_a_cnt", a_cnt, 0);
      chk("arst_a_empty", a_em, 1);
      chk("arst_c_cnt", c_cnt, 0);
      chk("arst_a_valid", a_vo, 0);
      #3 rst_n = 1'b1;

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ext_fifo_ipa.md
# ext_fifo_ipa

Parametrised single-clock FIFO for the extension unit, successor to the fixed two-entry elastic buffer. It generalises depth to any value of 1 or more, not restricted to powers of two. It adds an optional zero-latency fall-through path, a synchronous flush, an occupancy count and an almost-full flag. It sits on valid/ready streams between the extension unit and its producers and consumers, wherever back-pressure absorption or credit/threshold signalling is needed.

## Interface
- DATA_WIDTH, 32, payload width in bits
- BUFFER_DEPTH, 4, number of storage entries; legal range is 1 or more
- ALMOST_FULL_TH, BUFFER_DEPTH-1, almost_full_o asserts when count_o >= this value; legal range 1..BUFFER_DEPTH
- FALL_THROUGH, 0, 1 enables the combinational bypass when the FIFO is empty
- CNT_W, $clog2(BUFFER_DEPTH+1), width of count_o (derived, do not override)
- clk_i  in  1  clock; all state changes on the rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- flush_i  in  1  synchronous clear of all buffered entries
- valid_i  in  1  input beat valid
- data_i  in  DATA_WIDTH  input payload
- ready_o  out  1  FIFO can accept a beat
- valid_o  out  1  output beat valid
- data_o  out  DATA_WIDTH  output payload
- ready_i  in  1  consumer accepts the beat
- count_o  out  CNT_W  number of stored entries, 0..BUFFER_DEPTH
- almost_full_o  out  1  count_o >= ALMOST_FULL_TH
- empty_o  out  1  count_o == 0

## Operation
- State: storage array[BUFFER_DEPTH], wr_ptr, rd_ptr (width max(1,$clog2(BUFFER_DEPTH))), count (CNT_W).
- full = (count == BUFFER_DEPTH). ready_o = !full && !flush_i. A beat is never accepted when full, even with a simultaneous pop; this keeps ready_o free of any ready_i path.
- push = valid_i && ready_o; pop = valid_o && ready_i.
- Registered mode (FALL_THROUGH=0):
  - valid_o = (count != 0) && !flush_i.
  - data_o = storage[rd_ptr].
  - On push, write storage[wr_ptr] and advance wr_ptr. On pop, advance rd_ptr.
- Fall-through mode (FALL_THROUGH=1), when count == 0:
  - valid_o = valid_i && !flush_i, data_o = data_i.
  - If ready_i is also high, the beat passes through. Nothing is written; pointers and count are unchanged.
  - If ready_i is low, the beat is written and counts as a normal push.
  - When count != 0, behaviour is identical to registered mode. Ordering is preserved.
- Pointer wrap: a pointer at BUFFER_DEPTH-1 advances to 0. Non-power-of-two depths must wrap correctly. With BUFFER_DEPTH=1, pointers are constant 0.
- Count update:
  - +1 on push without pop.
  - −1 on pop without push.
  - Unchanged on both, or on neither.
  - A fall-through bypass counts as neither.
  - Count never underflows or overflows; the handshake rules make both impossible.
- Flush: on a rising edge with flush_i=1, count, wr_ptr and rd_ptr go to 0. Flush overrides any push or pop in that cycle. Storage contents are not cleared.
- count_o, almost_full_o and empty_o are derived from registered count only. They are not adjusted combinationally for in-flight beats.

## Timing
- Reset values:
  - count_o=0, empty_o=1, almost_full_o=0, ready_o=1, valid_o=0 (FALL_THROUGH=1: valid_o follows valid_i).
  - Storage resets to 0, so data_o=0 in registered mode. With FALL_THROUGH=1, data_o follows data_i while empty.
- Asserting rst_ni mid-operation discards all entries immediately (asynchronously).
- Latency, input accepted to valid_o:
  - Registered mode: 1 cycle.
  - Fall-through into an empty FIFO: 0 cycles.
- Throughput: 1 beat/cycle sustained at any depth ≥2 while not full. At depth 1 in registered mode, throughput is 1 beat/2 cycles, because full blocks push.
- Handshake:
  - Once valid_o is high, data_o is stable until pop or flush.
  - ready_o depends only on count and flush_i.
  - valid_o depends on ready_i through no path; it depends on valid_i only when FALL_THROUGH=1.
- Flush cycle: ready_o=0 and valid_o=0 combinationally. On the next cycle, ready_o=1 and empty_o=1.

## Test plan
- Reset then fill. Setup: DEPTH=4, TH=3, FALL_THROUGH=0, ready_i=0; push 0xA0..0xA3 on consecutive cycles.
  - Required: count_o steps 1,2,3,4; almost_full_o rises with count 3; ready_o=0 at count 4.
  - A 5th valid_i beat (0xA4) is not accepted.
- Drain order. From the full state, ready_i=1 for 4 cycles.
  - Required: data_o=0xA0,0xA1,0xA2,0xA3, then valid_o=0 and empty_o=1.
- Wrap and non-power-of-two depth. Setup: DEPTH=3; streaming push and pop with ready_i toggling 1,0,1,0 over 20 beats 0..19.
  - Required: output sequence 0..19, no loss or duplication, count_o never exceeds 3.
- Simultaneous push and pop. At count 2, push and pop in the same cycle.
  - Required: count_o stays 2 and the next data_o is the oldest remaining entry.
- Fall-through. Setup: FALL_THROUGH=1, empty, valid_i=1, data_i=0x55, ready_i=1.
  - Required: valid_o=1 and data_o=0x55 in the same cycle; count_o stays 0.
  - Repeat with ready_i=0: count_o becomes 1 next cycle and data_o holds 0x55.
- Flush and reset mid-stream.
  - At count 3 with push and pop active, pulse flush_i for 1 cycle. Required: valid_o=0 and ready_o=0 during the pulse; count_o=0 after; the next push makes 1 cycle later data_o equal the new value.
  - Assert rst_ni low asynchronously between edges. Required: count_o=0 immediately.
